// File: rtl/alu_share_pkg.sv
// Shared constants and types for the ALU sharing arbiter.
// Includes the mode enum and a one-hot to index helper.
package alu_share_pkg;

    localparam int ALU_OP_W   = 6;
    localparam int ALU_FLAG_W = 4;
    localparam int FLAG_CARRY = 3;
    localparam int MAX_REQ    = 8;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational one-hot picker: the first request strictly after 'base' wins, wrapping.
// A base of N-1 turns it into a lowest-index-first priority picker.
module rr_pick #(
    parameter int N      = 3,
    parameter int BASE_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [BASE_W-1:0] base,
    output logic [N-1:0]      gnt
);

    logic              found_s;
    logic [BASE_W-1:0] idx_s;

    // Scan base+1 .. base+N modulo N and keep the first hit.
    always_comb begin
        gnt     = {N{1'b0}};
        found_s = 1'b0;
        idx_s   = {BASE_W{1'b0}};
        for (int k = 1; k <= N; k++) begin
            idx_s = BASE_W'((int'(base) + k) % N);
            if (req[idx_s] && !found_s) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-multiplexes one shared combinational ALU among NUM_REQ requesters with
// fixed-priority or round-robin grants, lock-based holding and a starvation guard.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int WIDTH    = 16,
    parameter int OP_W     = ALU_OP_W,
    parameter int MODE     = 0,
    parameter int MAX_LOCK = 32,
    parameter int RESP_REG = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0]    req_x,
    input  logic [NUM_REQ*WIDTH-1:0]    req_y,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic [OP_W-1:0]             alu_opcode,
    output logic [WIDTH-1:0]            alu_x_in,
    output logic [WIDTH-1:0]            alu_y_in,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic [ALU_FLAG_W-1:0]       alu_flags,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [WIDTH-1:0]            rsp_result,
    output logic [ALU_FLAG_W-1:0]       rsp_flags
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] gnt_r;
    logic [IDX_W-1:0]   owner_r;
    logic               busy_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   lock_cnt_r;

    logic [NUM_REQ-1:0] issue_vec_s;
    logic [NUM_REQ-1:0] others_s;
    logic [NUM_REQ-1:0] pick_req_s;
    logic [NUM_REQ-1:0] pick_gnt_s;
    logic [NUM_REQ-1:0] gnt_next_s;
    logic [IDX_W-1:0]   pick_base_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [CNT_W-1:0]   lock_cnt_s;
    logic               issue_s;
    logic               owner_lock_s;
    logic               trip_s;
    logic               hold_s;

    assign issue_vec_s  = gnt_r & req;
    assign issue_s      = |issue_vec_s;
    assign owner_lock_s = issue_s & lock[owner_r];
    assign others_s     = req & ~gnt_r;

    // Lock counter includes the current locked issue; the guard trips only when someone else waits.
    always_comb begin
        lock_cnt_s  = {CNT_W{1'b0}};
        trip_s      = 1'b0;
        hold_s      = 1'b0;
        pick_req_s  = req;
        pick_base_s = LAST_IDX;
        gnt_next_s  = {NUM_REQ{1'b0}};
        if (owner_lock_s) begin
            if (lock_cnt_r == LOCK_MAX) begin
                lock_cnt_s = lock_cnt_r;
            end else begin
                lock_cnt_s = lock_cnt_r + CNT_W'(1);
            end
        end else begin
            lock_cnt_s = {CNT_W{1'b0}};
        end
        trip_s     = (MAX_LOCK != 0) && owner_lock_s && (lock_cnt_s == LOCK_MAX) && (|others_s);
        hold_s     = owner_lock_s && !trip_s;
        pick_req_s = trip_s ? others_s : req;
        if (MODE == int'(ARB_RR)) begin
            pick_base_s = rr_ptr_r;
        end else begin
            pick_base_s = LAST_IDX;
        end
        gnt_next_s = hold_s ? gnt_r : pick_gnt_s;
    end

    rr_pick #(
        .N      (NUM_REQ),
        .BASE_W (IDX_W)
    ) u_pick (
        .req  (pick_req_s),
        .base (pick_base_s),
        .gnt  (pick_gnt_s)
    );

    assign pick_idx_s = IDX_W'(onehot_to_idx(MAX_REQ'(pick_gnt_s)));

    // Grant, owner, lock counter and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r      <= {NUM_REQ{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            busy_r     <= 1'b0;
            lock_cnt_r <= {CNT_W{1'b0}};
            rr_ptr_r   <= LAST_IDX;
        end else begin
            gnt_r      <= gnt_next_s;
            owner_r    <= hold_s ? owner_r : pick_idx_s;
            busy_r     <= |gnt_next_s;
            lock_cnt_r <= trip_s ? {CNT_W{1'b0}} : lock_cnt_s;
            if (!hold_s && (|pick_gnt_s)) begin
                rr_ptr_r <= pick_idx_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign gnt   = gnt_r;
    assign busy  = busy_r;
    assign owner = owner_r;

    // Shared ALU sees the owner's operands only on an issue, zeros otherwise.
    always_comb begin
        alu_opcode = {OP_W{1'b0}};
        alu_x_in   = {WIDTH{1'b0}};
        alu_y_in   = {WIDTH{1'b0}};
        if (issue_s) begin
            alu_opcode = req_op[int'(owner_r) * OP_W +: OP_W];
            alu_x_in   = req_x[int'(owner_r) * WIDTH +: WIDTH];
            alu_y_in   = req_y[int'(owner_r) * WIDTH +: WIDTH];
        end else begin
            alu_opcode = {OP_W{1'b0}};
        end
    end

    if (RESP_REG != 0) begin : g_rsp_reg
        logic [NUM_REQ-1:0]    rsp_valid_r;
        logic [WIDTH-1:0]      rsp_result_r;
        logic [ALU_FLAG_W-1:0] rsp_flags_r;

        // Registered response; data holds between valids.
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_r  <= {NUM_REQ{1'b0}};
                rsp_result_r <= {WIDTH{1'b0}};
                rsp_flags_r  <= {ALU_FLAG_W{1'b0}};
            end else begin
                rsp_valid_r <= issue_vec_s;
                if (issue_s) begin
                    rsp_result_r <= alu_result;
                    rsp_flags_r  <= alu_flags;
                end else begin
                    rsp_result_r <= rsp_result_r;
                    rsp_flags_r  <= rsp_flags_r;
                end
            end
        end

        assign rsp_valid  = rsp_valid_r;
        assign rsp_result = rsp_result_r;
        assign rsp_flags  = rsp_flags_r;
    end else begin : g_rsp_comb
        logic [WIDTH-1:0]      last_result_r;
        logic [ALU_FLAG_W-1:0] last_flags_r;

        // Remember the last result so the outputs hold while idle.
        always_ff @(posedge clk) begin
            if (rst) begin
                last_result_r <= {WIDTH{1'b0}};
                last_flags_r  <= {ALU_FLAG_W{1'b0}};
            end else if (issue_s) begin
                last_result_r <= alu_result;
                last_flags_r  <= alu_flags;
            end else begin
                last_result_r <= last_result_r;
                last_flags_r  <= last_flags_r;
            end
        end

        assign rsp_valid  = issue_vec_s;
        assign rsp_result = issue_s ? alu_result : last_result_r;
        assign rsp_flags  = issue_s ? alu_flags : last_flags_r;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: instance 0 is fixed priority, instance 1 round-robin, both with MAX_LOCK=4.
// Expected responses are queued at issue and compared when the DUT answers.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int OPW = 6;
    localparam logic [OPW-1:0] OP_ADD = 6'd1;
    localparam logic [OPW-1:0] OP_SUB = 6'd2;

    typedef struct {
        logic [N-1:0] who;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a       [2];
    logic [N-1:0]     req_a       [2];
    logic [N-1:0]     lock_a      [2];
    logic [N*OPW-1:0] op_a        [2];
    logic [N*W-1:0]   x_a         [2];
    logic [N*W-1:0]   y_a         [2];
    logic [N-1:0]     gnt_a       [2];
    logic             busy_a      [2];
    logic [1:0]       owner_a     [2];
    logic [OPW-1:0]   alu_op_a    [2];
    logic [W-1:0]     alu_x_a     [2];
    logic [W-1:0]     alu_y_a     [2];
    logic [W-1:0]     alu_res_a   [2];
    logic [3:0]       alu_fl_a    [2];
    logic [N-1:0]     rsp_valid_a [2];
    logic [W-1:0]     rsp_res_a   [2];
    logic [3:0]       rsp_fl_a    [2];

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t rsp_q[$];

    // Reference ALU: flags = {carry, msb, zero, 0}.
    function automatic logic [19:0] bench_alu(input logic [OPW-1:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [W:0] s;
        case (op)
            OP_ADD:  s = {1'b0, x} + {1'b0, y};
            OP_SUB:  s = {1'b0, x} - {1'b0, y};
            default: s = {1'b0, x ^ y};
        endcase
        return {s[FLAG_CARRY + 13], s[W-1], (s[W-1:0] == 16'h0000), 1'b0, s[W-1:0]};
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        int k = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) k = i;
        end
        return k;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_share_arbiter #(
            .NUM_REQ (N), .WIDTH (W), .OP_W (OPW), .MODE (g), .MAX_LOCK (4), .RESP_REG (1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_a[g]),
            .req        (req_a[g]),
            .lock       (lock_a[g]),
            .req_op     (op_a[g]),
            .req_x      (x_a[g]),
            .req_y      (y_a[g]),
            .gnt        (gnt_a[g]),
            .busy       (busy_a[g]),
            .owner      (owner_a[g]),
            .alu_opcode (alu_op_a[g]),
            .alu_x_in   (alu_x_a[g]),
            .alu_y_in   (alu_y_a[g]),
            .alu_result (alu_res_a[g]),
            .alu_flags  (alu_fl_a[g]),
            .rsp_valid  (rsp_valid_a[g]),
            .rsp_result (rsp_res_a[g]),
            .rsp_flags  (rsp_fl_a[g])
        );
        assign {alu_fl_a[g], alu_res_a[g]} = bench_alu(alu_op_a[g], alu_x_a[g], alu_y_a[g]);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the grant expected this cycle and last cycle's response.
    task automatic step(input int d, input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N-1:0] eg, input string tag, input logic rs = 1'b0);
        rsp_t        e;
        int          c;
        logic [19:0] a;
        @(posedge clk);
        #1;
        req_a[d]  = r;
        lock_a[d] = l;
        rst_a[d]  = rs;
        #1;
        check_eq({tag, "_gnt"}, 32'(gnt_a[d]), 32'(eg));
        check_eq({tag, "_busy"}, 32'(busy_a[d]), 32'(|eg));
        check_eq({tag, "_owner"}, 32'(owner_a[d]), 32'(oh2i(eg)));
        if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            check_eq({tag, "_rsp_valid"}, 32'(rsp_valid_a[d]), 32'(e.who));
            check_eq({tag, "_rsp_result"}, 32'(rsp_res_a[d]), 32'(e.res));
            check_eq({tag, "_rsp_flags"}, 32'(rsp_fl_a[d]), 32'(e.fl));
        end else begin
            check_eq({tag, "_rsp_idle"}, 32'(rsp_valid_a[d]), 32'd0);
        end
        if ((eg & r) != 3'b000) begin
            c = oh2i(eg);
            a = bench_alu(op_a[d][c*OPW +: OPW], x_a[d][c*W +: W], y_a[d][c*W +: W]);
            check_eq({tag, "_alu_x"}, 32'(alu_x_a[d]), 32'(x_a[d][c*W +: W]));
            if (!rs) rsp_q.push_back('{who: eg, res: a[15:0], fl: a[19:16]});
        end else begin
            check_eq({tag, "_alu_idle"}, 32'({alu_op_a[d], alu_x_a[d], alu_y_a[d]}), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d]  = 1'b1;
            req_a[d]  = 3'b000;
            lock_a[d] = 3'b000;
            op_a[d]   = {OP_SUB, OP_ADD, OP_ADD};
            x_a[d]    = {16'h0100, 16'h0005, 16'hFFFF};
            y_a[d]    = {16'h0001, 16'h0003, 16'h0002};
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_gnt", 32'(gnt_a[d]), 32'd0);
            check_eq("reset_busy_owner", 32'({busy_a[d], owner_a[d]}), 32'd0);
            check_eq("reset_rsp", 32'({rsp_valid_a[d], rsp_fl_a[d], rsp_res_a[d]}), 32'd0);
            rst_a[d] = 1'b0;
        end

        // Single request, ADD 5+3 from client 1.
        step(0, 3'b010, 3'b000, 3'b000, "single_t0");
        step(0, 3'b010, 3'b000, 3'b010, "single_t1");
        step(0, 3'b000, 3'b000, 3'b010, "single_t2");
        check_eq("single_result", 32'(rsp_res_a[0]), 32'h0008);
        step(0, 3'b000, 3'b000, 3'b000, "single_t3");
        check_eq("single_hold", 32'(rsp_res_a[0]), 32'h0008);

        // Fixed priority: client 0 keeps winning; its ADD carries out.
        step(0, 3'b111, 3'b000, 3'b000, "fp_t0");
        for (int i = 0; i < 3; i++) step(0, 3'b111, 3'b000, 3'b001, "fp_hold");
        step(0, 3'b000, 3'b000, 3'b001, "fp_t4");
        step(0, 3'b000, 3'b000, 3'b000, "fp_t5");

        // Client 2 drops req in its grant cycle: no issue, no response.
        step(0, 3'b100, 3'b000, 3'b000, "drop_t0");
        step(0, 3'b000, 3'b000, 3'b100, "drop_t1");
        step(0, 3'b000, 3'b000, 3'b000, "drop_t2");

        // Lock saturation with no contender, then guard trip, then reset mid-lock.
        step(0, 3'b100, 3'b100, 3'b000, "sat_t0");
        for (int i = 0; i < 6; i++) step(0, 3'b100, 3'b100, 3'b100, "sat_hold");
        step(0, 3'b101, 3'b100, 3'b100, "sat_trip");
        step(0, 3'b101, 3'b000, 3'b001, "sat_c0");
        step(0, 3'b100, 3'b100, 3'b001, "sat_c0drop");
        step(0, 3'b100, 3'b100, 3'b100, "sat_regain");
        step(0, 3'b100, 3'b100, 3'b100, "rst_mid", 1'b1);
        step(0, 3'b000, 3'b000, 3'b000, "rst_after");
        check_eq("rst_after_data", 32'({rsp_fl_a[0], rsp_res_a[0]}), 32'd0);

        // Round-robin rotation.
        step(1, 3'b111, 3'b000, 3'b000, "rr_t0");
        step(1, 3'b111, 3'b000, 3'b001, "rr_t1");
        step(1, 3'b111, 3'b000, 3'b010, "rr_t2");
        step(1, 3'b111, 3'b000, 3'b100, "rr_t3");
        step(1, 3'b111, 3'b000, 3'b001, "rr_t4");
        step(1, 3'b000, 3'b000, 3'b010, "rr_t5");
        step(1, 3'b000, 3'b000, 3'b000, "rr_t6");

        // Lock with guard: client 1 holds 4 issues, client 0 served once, client 1 regains.
        step(1, 3'b010, 3'b010, 3'b000, "lock_t0");
        for (int i = 0; i < 4; i++) step(1, 3'b011, 3'b010, 3'b010, "lock_hold");
        step(1, 3'b011, 3'b010, 3'b001, "lock_guard");
        step(1, 3'b010, 3'b010, 3'b010, "lock_regain");
        step(1, 3'b000, 3'b000, 3'b010, "lock_drop");
        step(1, 3'b000, 3'b000, 3'b000, "lock_idle");

        check_eq("scoreboard_empty", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Parametrised successor to the fixed three-way CPU/multiply/divide ALU arbiter. It time-multiplexes one shared combinational ALU among `NUM_REQ` requesters using fixed-priority or round-robin arbitration. Multi-op sequences (e.g. multiply/divide FSM iterations) hold the ALU with a lock, bounded by a starvation guard. It sits between the requesters and the single `ALU` instance in `system_top`, and returns each result with a per-client valid.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8; index 0 is the CPU by convention.
- `WIDTH`, default 16: operand and result width.
- `OP_W`, default 6: ALU opcode width.
- `MODE`, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `MAX_LOCK`, default 32: maximum consecutive locked cycles before forced release; 0 disables the guard.
- `RESP_REG`, default 1: 1 registers the response (one cycle after issue); 0 makes the response combinational in the issue cycle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: per-client request.
- `lock` in `NUM_REQ`: per-client hold-grant-after-this-op.
- `req_op` in `NUM_REQ*OP_W`: flattened opcodes; client i occupies bits [i*OP_W +: OP_W].
- `req_x`, `req_y` in `NUM_REQ*WIDTH`: flattened operands.
- `gnt` out `NUM_REQ`: registered one-hot grant.
- `busy` out 1: high when any `gnt` bit is set.
- `owner` out `$clog2(NUM_REQ)`: index of the granted client; 0 when idle.
- `alu_opcode` out `OP_W`, `alu_x_in` out `WIDTH`, `alu_y_in` out `WIDTH`: drive the shared ALU.
- `alu_result` in `WIDTH`, `alu_flags` in 4: from the shared ALU; flags[3] = carry.
- `rsp_valid` out `NUM_REQ`: one-hot; the result belongs to that client.
- `rsp_result` out `WIDTH`, `rsp_flags` out 4: response data.

## Operation
- State is `gnt` only; each cycle holds either no owner (IDLE) or exactly one (OWNED).
- Issue: a cycle with `gnt[i] && req[i]` is an issue. The ALU is driven from client i's op/x/y in that cycle.
- With no issue (idle, or the owner dropped `req`), the ALU inputs are driven to 0.
- Next-grant rule, evaluated every cycle:
  - If the owner has `req && lock` and the guard has not tripped, keep the owner.
  - Otherwise, pick from the current `req` vector:
    - `MODE=0`: lowest set index wins.
    - `MODE=1`: the first set index strictly after `rr_ptr`, wrapping around. `rr_ptr` updates to the winner when a new grant is made.
  - If no `req` bit is set, the next state is IDLE.
- A non-locked grant lasts exactly one cycle. A client that keeps `req` high can be regranted:
  - immediately in `MODE=0`;
  - in `MODE=1`, only after all other pending clients have been served.
- Starvation guard:
  - `lock_cnt` counts consecutive cycles in which the owner issues with `lock` high.
  - When `lock_cnt == MAX_LOCK` and another client has `req` set, the owner is excluded from the next pick for one cycle and `lock_cnt` clears.
  - If no other client is requesting, the owner keeps the grant and `lock_cnt` saturates.
- A client must hold `req`, op and operands stable until it sees `gnt`. Dropping `req` while granted gives no issue and no response; the grant is released at the next edge regardless of `lock`.
- Response:
  - `RESP_REG=1`: `rsp_valid[i]`, `rsp_result` and `rsp_flags` are registered one cycle after the issue.
  - `RESP_REG=0`: they are combinational in the issue cycle.
  - `rsp_result` and `rsp_flags` hold their last value when `rsp_valid` is 0.
- Width rule: the arbiter passes results straight through and performs no arithmetic. `WIDTH` must match the ALU width.

## Timing
- Reset values:
  - `gnt=0`, `busy=0`, `owner=0`;
  - `rsp_valid=0`, `rsp_result=0`, `rsp_flags=0`;
  - `lock_cnt=0`;
  - `rr_ptr=NUM_REQ-1`, so client 0 is first in round-robin.
- Latency: `req` rising in cycle t gives `gnt` in t+1 (if it wins), issue in t+1, and `rsp_valid` in t+2 (`RESP_REG=1`) or t+1 (`RESP_REG=0`).
- Back-to-back: the ALU can be issued every cycle with no idle gap between different owners.
- Simultaneous requests: exactly one grant; the losers are not issued and keep waiting.
- Reset mid-operation: the grant is dropped and any pending registered response is discarded, with no `rsp_valid` after the reset edge.

## Structure
- Package `alu_share_pkg` holds:
  - `ALU_OP_W=6`, `ALU_FLAG_W=4`, `FLAG_CARRY=3`;
  - the `arb_mode_e` enum {`ARB_FIXED`, `ARB_RR`}.
- Sub-module `rr_pick`: combinational one-hot picker over an N-bit request vector with a rotating base index. `MODE=0` uses base = N-1.
- Top level: grant register, `lock_cnt`, `rr_ptr`, operand muxes and the response register.

## Test plan
All scenarios use `NUM_REQ=3`, `WIDTH=16`, `RESP_REG=1` unless stated.
- Single request, non-round-robin: `req=3'b010`, op=ADD, x=16'h0005, y=16'h0003 at t0 → `gnt=3'b010` at t1, `alu_x_in=5`; at t2 `rsp_valid=3'b010` and `rsp_result=16'h0008`.
- Fixed priority (`MODE=0`): `req=3'b111` held for 3 cycles, no locks → `gnt=001` in each of t1, t2, t3.
- Round-robin (`MODE=1`): `req=3'b111` held → `gnt` sequence 001, 010, 100, 001.
- Lock with guard (`MAX_LOCK=4`): client 1 locked with `req=1`, client 0 requesting → client 1 is granted for 4 issue cycles, then `gnt=001` for one cycle, then client 1 regains the grant.
- Request dropped while granted: client 2 lowers `req` in its grant cycle → no `rsp_valid[2]`; `gnt=0` on the next cycle.
- Reset mid-operation: `rst` asserted the cycle after an issue → all outputs 0 at the next edge and no response.
